// File: rtl/regfile.sv
// 32-entry integer register file with two combinational read ports, write-through
// bypass, a per-register pending-write scoreboard and a committed-write counter.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif
`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif
`ifndef READ_ENABLE
`define READ_ENABLE 1'b1
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

module regfile (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [`RADDR_WIDTH-1:0]   waddr_i,
  input  logic [`RDATA_WIDTH-1:0]   wdata_i,
  input  logic                      reg1_re_i,
  input  logic [`RADDR_WIDTH-1:0]   reg1_raddr_i,
  output logic [`RDATA_WIDTH-1:0]   reg1_rdata_o,
  input  logic                      reg2_re_i,
  input  logic [`RADDR_WIDTH-1:0]   reg2_raddr_i,
  output logic [`RDATA_WIDTH-1:0]   reg2_rdata_o,
  input  logic                      rsv_i,
  input  logic [`RADDR_WIDTH-1:0]   rsv_addr_i,
  output logic                      reg1_busy_o,
  output logic                      reg2_busy_o,
  output logic [31:0]               wr_cnt_o
);

  logic [`RDATA_WIDTH-1:0] regs_q [32];
  logic [`RDATA_WIDTH-1:0] regs_d [32];
  logic [31:0]             busy_q;
  logic [31:0]             busy_d;
  logic [31:0]             wr_cnt_q;
  logic [31:0]             wr_cnt_d;
  logic                    wr_commit_s;
  logic                    rsv_valid_s;

  assign wr_commit_s = (we_i == `WRITE_ENABLE) && (waddr_i != `ZERO_REG);
  assign rsv_valid_s = rsv_i && (rsv_addr_i != `ZERO_REG);

  // Next-state for storage and the write counter
  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_commit_s) begin
      regs_d[waddr_i] = wdata_i;
      wr_cnt_d        = wr_cnt_q + 32'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    regs_d[0] = {`RDATA_WIDTH{1'b0}};
  end

  // Scoreboard next-state: clear first so a same-address reservation wins
  always_comb begin
    busy_d = busy_q;
    if (wr_commit_s) begin
      busy_d[waddr_i] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (rsv_valid_s) begin
      busy_d[rsv_addr_i] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q   <= '{default: '0};
      busy_q   <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Port 1 read data with write-through bypass
  always_comb begin
    reg1_rdata_o = {`RDATA_WIDTH{1'b0}};
    if (reg1_re_i != `READ_ENABLE || reg1_raddr_i == `ZERO_REG) begin
      reg1_rdata_o = {`RDATA_WIDTH{1'b0}};
    end else if (wr_commit_s && waddr_i == reg1_raddr_i) begin
      reg1_rdata_o = wdata_i;
    end else begin
      reg1_rdata_o = regs_q[reg1_raddr_i];
    end
  end

  // Port 2 read data with write-through bypass
  always_comb begin
    reg2_rdata_o = {`RDATA_WIDTH{1'b0}};
    if (reg2_re_i != `READ_ENABLE || reg2_raddr_i == `ZERO_REG) begin
      reg2_rdata_o = {`RDATA_WIDTH{1'b0}};
    end else if (wr_commit_s && waddr_i == reg2_raddr_i) begin
      reg2_rdata_o = wdata_i;
    end else begin
      reg2_rdata_o = regs_q[reg2_raddr_i];
    end
  end

  // Hazard flags: a write-back in the same cycle releases the hazard
  always_comb begin
    reg1_busy_o = 1'b0;
    reg2_busy_o = 1'b0;
    if (reg1_re_i == `READ_ENABLE && reg1_raddr_i != `ZERO_REG) begin
      reg1_busy_o = busy_q[reg1_raddr_i] && !(wr_commit_s && waddr_i == reg1_raddr_i);
    end else begin
      reg1_busy_o = 1'b0;
    end
    if (reg2_re_i == `READ_ENABLE && reg2_raddr_i != `ZERO_REG) begin
      reg2_busy_o = busy_q[reg2_raddr_i] && !(wr_commit_s && waddr_i == reg2_raddr_i);
    end else begin
      reg2_busy_o = 1'b0;
    end
  end

  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reads, bypass, scoreboard, reset, counter wrap.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        reg1_re_i, reg2_re_i;
  logic [4:0]  reg1_raddr_i, reg2_raddr_i;
  logic [31:0] reg1_rdata_o, reg2_rdata_o;
  logic        rsv_i;
  logic [4:0]  rsv_addr_i;
  logic        reg1_busy_o, reg2_busy_o;
  logic [31:0] wr_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = 32'd0;

  regfile dut (
    .clk(clk), .rst(rst),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .reg1_re_i(reg1_re_i), .reg1_raddr_i(reg1_raddr_i), .reg1_rdata_o(reg1_rdata_o),
    .reg2_re_i(reg2_re_i), .reg2_raddr_i(reg2_raddr_i), .reg2_rdata_o(reg2_rdata_o),
    .rsv_i(rsv_i), .rsv_addr_i(rsv_addr_i),
    .reg1_busy_o(reg1_busy_o), .reg2_busy_o(reg2_busy_o),
    .wr_cnt_o(wr_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0;
    rsv_i = 1'b0; rsv_addr_i = 5'd0;
    reg1_re_i = 1'b0; reg1_raddr_i = 5'd0;
    reg2_re_i = 1'b0; reg2_raddr_i = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd5;
    reg2_re_i = 1'b1; reg2_raddr_i = 5'd5;
    #1;
    n_cmp++; if (reg1_rdata_o !== 32'd0) begin n_err++; $display("FAIL reset_rd1 got %h want %h", reg1_rdata_o, 32'd0); end
    n_cmp++; if (reg1_busy_o !== 1'b0 || reg2_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b%b want 00", reg1_busy_o, reg2_busy_o); end
    n_cmp++; if (wr_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %h want %h", wr_cnt_o, 32'd0); end
    // write and reservation during reset must be discarded
    we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hAAAA_AAAA;
    rsv_i = 1'b1; rsv_addr_i = 5'd5;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd5;
    #1;
    n_cmp++; if (reg1_rdata_o !== 32'd0) begin n_err++; $display("FAIL reset_discard_wr got %h want %h", reg1_rdata_o, 32'd0); end
    n_cmp++; if (reg1_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_discard_rsv got %b want 0", reg1_busy_o); end
    n_cmp++; if (wr_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_discard_cnt got %h want %h", wr_cnt_o, 32'd0); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_idle();
    we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'd1;
    set_idle();
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd5;
    reg2_re_i = 1'b1; reg2_raddr_i = 5'd0;
    #1;
    n_cmp++; if (reg1_rdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rd_x5 got %h want %h", reg1_rdata_o, 32'hDEAD_BEEF); end
    n_cmp++; if (reg2_rdata_o !== 32'd0) begin n_err++; $display("FAIL wr_rd_x0 got %h want %h", reg2_rdata_o, 32'd0); end
    n_cmp++; if (wr_cnt_o !== exp_cnt) begin n_err++; $display("FAIL wr_rd_cnt got %h want %h", wr_cnt_o, exp_cnt); end
    reg2_raddr_i = 5'd5;
    #1;
    n_cmp++; if (reg2_rdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL same_addr_p2 got %h want %h", reg2_rdata_o, 32'hDEAD_BEEF); end
    reg1_re_i = 1'b0;
    #1;
    n_cmp++; if (reg1_rdata_o !== 32'd0) begin n_err++; $display("FAIL re_off got %h want %h", reg1_rdata_o, 32'd0); end
  endtask

  task automatic test_bypass_x0();
    @(negedge clk);
    set_idle();
    we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h0000_1234;
    reg2_re_i = 1'b1; reg2_raddr_i = 5'd7;
    #1;
    n_cmp++; if (reg2_rdata_o !== 32'h0000_1234) begin n_err++; $display("FAIL bypass got %h want %h", reg2_rdata_o, 32'h0000_1234); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'd1;
    set_idle();
    we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'h0000_FFFF;
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd0;
    reg2_re_i = 1'b1; reg2_raddr_i = 5'd7;
    #1;
    n_cmp++; if (reg1_rdata_o !== 32'd0) begin n_err++; $display("FAIL x0_no_bypass got %h want %h", reg1_rdata_o, 32'd0); end
    n_cmp++; if (reg2_rdata_o !== 32'h0000_1234) begin n_err++; $display("FAIL x7_stored got %h want %h", reg2_rdata_o, 32'h0000_1234); end
    @(posedge clk); #1;
    we_i = 1'b0;
    #1;
    n_cmp++; if (reg1_rdata_o !== 32'd0) begin n_err++; $display("FAIL x0_after_wr got %h want %h", reg1_rdata_o, 32'd0); end
    n_cmp++; if (wr_cnt_o !== exp_cnt) begin n_err++; $display("FAIL x0_cnt got %h want %h", wr_cnt_o, exp_cnt); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    set_idle();
    rsv_i = 1'b1; rsv_addr_i = 5'd3;
    @(posedge clk); #1;
    set_idle();
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd3;
    reg2_re_i = 1'b0; reg2_raddr_i = 5'd3;
    #1;
    n_cmp++; if (reg1_busy_o !== 1'b1) begin n_err++; $display("FAIL hazard_set got %b want 1", reg1_busy_o); end
    n_cmp++; if (reg2_busy_o !== 1'b0) begin n_err++; $display("FAIL hazard_re_off got %b want 0", reg2_busy_o); end
    we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h0000_0033;
    #1;
    n_cmp++; if (reg1_busy_o !== 1'b0) begin n_err++; $display("FAIL hazard_wb_release got %b want 0", reg1_busy_o); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'd1;
    we_i = 1'b0;
    #1;
    n_cmp++; if (reg1_busy_o !== 1'b0) begin n_err++; $display("FAIL hazard_cleared got %b want 0", reg1_busy_o); end
    n_cmp++; if (reg1_rdata_o !== 32'h0000_0033) begin n_err++; $display("FAIL hazard_data got %h want %h", reg1_rdata_o, 32'h0000_0033); end
  endtask

  task automatic test_set_clear();
    @(negedge clk);
    set_idle();
    rsv_i = 1'b1; rsv_addr_i = 5'd4;
    we_i = 1'b1; waddr_i = 5'd4; wdata_i = 32'h0000_0044;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'd1;
    set_idle();
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd4;
    #1;
    n_cmp++; if (reg1_busy_o !== 1'b1) begin n_err++; $display("FAIL same_addr_set_wins got %b want 1", reg1_busy_o); end
    n_cmp++; if (reg1_rdata_o !== 32'h0000_0044) begin n_err++; $display("FAIL same_addr_data got %h want %h", reg1_rdata_o, 32'h0000_0044); end
    // different addresses: clear x4, set x6
    rsv_i = 1'b1; rsv_addr_i = 5'd6;
    we_i = 1'b1; waddr_i = 5'd4; wdata_i = 32'h0000_0444;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'd1;
    set_idle();
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd4;
    reg2_re_i = 1'b1; reg2_raddr_i = 5'd6;
    #1;
    n_cmp++; if (reg1_busy_o !== 1'b0 || reg2_busy_o !== 1'b1) begin n_err++; $display("FAIL diff_addr_busy got %b%b want 01", reg1_busy_o, reg2_busy_o); end
    rsv_i = 1'b1; rsv_addr_i = 5'd0;
    @(posedge clk); #1;
    set_idle();
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd0;
    #1;
    n_cmp++; if (reg1_busy_o !== 1'b0) begin n_err++; $display("FAIL rsv_x0 got %b want 0", reg1_busy_o); end
    n_cmp++; if (wr_cnt_o !== exp_cnt) begin n_err++; $display("FAIL set_clear_cnt got %h want %h", wr_cnt_o, exp_cnt); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      set_idle();
      we_i = 1'b1; waddr_i = 5'(i); wdata_i = 32'h1000_0000 + 32'(i);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 32'd1;
    end
    set_idle();
    rsv_i = 1'b1; rsv_addr_i = 5'd9;
    @(posedge clk); #1;
    set_idle();
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd31;
    reg2_re_i = 1'b1; reg2_raddr_i = 5'd9;
    #1;
    n_cmp++; if (reg1_rdata_o !== 32'h1000_001F) begin n_err++; $display("FAIL fill_x31 got %h want %h", reg1_rdata_o, 32'h1000_001F); end
    n_cmp++; if (reg2_busy_o !== 1'b1) begin n_err++; $display("FAIL fill_rsv_x9 got %b want 1", reg2_busy_o); end
    n_cmp++; if (wr_cnt_o !== exp_cnt) begin n_err++; $display("FAIL fill_cnt got %h want %h", wr_cnt_o, exp_cnt); end
    // assert reset between edges; effects must be visible before any edge
    rst = 1'b1;
    #1;
    n_cmp++; if (reg1_rdata_o !== 32'd0 || reg2_rdata_o !== 32'd0) begin n_err++; $display("FAIL async_rst_rd got %h/%h want 0", reg1_rdata_o, reg2_rdata_o); end
    n_cmp++; if (reg2_busy_o !== 1'b0) begin n_err++; $display("FAIL async_rst_busy got %b want 0", reg2_busy_o); end
    n_cmp++; if (wr_cnt_o !== 32'd0) begin n_err++; $display("FAIL async_rst_cnt got %h want %h", wr_cnt_o, 32'd0); end
    exp_cnt = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    we_i = 1'b1; waddr_i = 5'd2; wdata_i = 32'h0000_0022;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'd1;
    set_idle();
    reg1_re_i = 1'b1; reg1_raddr_i = 5'd2;
    reg2_re_i = 1'b1; reg2_raddr_i = 5'd9;
    #1;
    n_cmp++; if (reg1_rdata_o !== 32'h0000_0022) begin n_err++; $display("FAIL post_rst_wr got %h want %h", reg1_rdata_o, 32'h0000_0022); end
    n_cmp++; if (reg2_busy_o !== 1'b0 || reg2_rdata_o !== 32'd0) begin n_err++; $display("FAIL post_rst_x9 got busy %b data %h want 0/0", reg2_busy_o, reg2_rdata_o); end
    n_cmp++; if (wr_cnt_o !== exp_cnt) begin n_err++; $display("FAIL post_rst_cnt got %h want %h", wr_cnt_o, exp_cnt); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    set_idle();
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    #1;
    n_cmp++; if (wr_cnt_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload got %h want %h", wr_cnt_o, 32'hFFFF_FFFF); end
    we_i = 1'b1; waddr_i = 5'd10; wdata_i = 32'h0000_00A0;
    @(posedge clk); #1;
    set_idle();
    #1;
    n_cmp++; if (wr_cnt_o !== 32'd0) begin n_err++; $display("FAIL wrap_cnt got %h want %h", wr_cnt_o, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass_x0();
    test_hazard();
    test_set_clear();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The module SHALL have these ports, one per line: name  direction  width  meaning.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 we_i  input  1  write-back enable (`WRITE_ENABLE` = write).
REQ-005 waddr_i  input  `RADDR_WIDTH  write-back register address.
REQ-006 wdata_i  input  `RDATA_WIDTH  write-back data.
REQ-007 reg1_re_i  input  1  port-1 read enable (`READ_ENABLE` = read).
REQ-008 reg1_raddr_i  input  `RADDR_WIDTH  port-1 read address.
REQ-009 reg1_rdata_o  output  `RDATA_WIDTH  port-1 read data.
REQ-010 reg2_re_i, reg2_raddr_i, reg2_rdata_o  same widths as port 1  port-2 read enable, address and data.
REQ-011 rsv_i  input  1  issue-time reservation strobe; marks the destination register pending.
REQ-012 rsv_addr_i  input  `RADDR_WIDTH  register to reserve.
REQ-013 reg1_busy_o, reg2_busy_o  output  1 each  read register has a pending write (hazard flag to the decoder).
REQ-014 wr_cnt_o  output  32  count of committed writes to nonzero registers.

Function
REQ-015 Storage SHALL be 32 registers of `RDATA_WIDTH bits; x0 (`ZERO_REG`) SHALL always read 0 and SHALL ignore writes.
REQ-016 A write SHALL commit on the rising clk edge when we_i=1 and waddr_i!=0.
REQ-017 Reads SHALL be combinational, with zero latency.
REQ-018 Read ports: re=0 -> 0; raddr=0 -> 0; re=1, raddr!=0, we_i=1, waddr_i==raddr -> wdata_i (write-through bypass); otherwise the stored value.
REQ-019 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-020 The scoreboard SHALL hold one busy bit per register; bit 0 SHALL be constant 0.
REQ-021 Set: on a rising edge with rsv_i=1 and rsv_addr_i!=0, busy[rsv_addr_i] SHALL become 1.
REQ-022 Clear: on a rising edge with we_i=1 and waddr_i!=0, busy[waddr_i] SHALL become 0.
REQ-023 Simultaneous set and clear on the same address SHALL leave the bit at 1 (the newer reservation wins).
REQ-024 Simultaneous set and clear on different addresses SHALL apply both.
REQ-025 regN_busy_o SHALL be busy[raddr] AND reN AND NOT (we_i AND waddr_i==raddr), so a same-cycle write-back releases the hazard.
REQ-026 regN_busy_o SHALL be 0 when raddr=0 or reN=0.
REQ-027 Writes SHALL be allowed to a register that is not busy; data commits and the busy bit stays 0.
REQ-028 wr_cnt_o SHALL increment by 1 on each committed write with waddr_i!=0, wrap modulo 2^32, and ignore writes to x0.

Reset
REQ-029 While rst=1, asynchronously: all registers SHALL be 0, all busy bits 0, and wr_cnt_o 0.
REQ-030 As a consequence of REQ-029, while rst=1 every read port SHALL return 0 or the bypass value, and every busy output SHALL be 0.
REQ-031 A write or reservation on the same edge as rst=1 SHALL be discarded.
REQ-032 Reset asserted mid-operation SHALL clear all pending reservations.
REQ-033 The first edge after rst deasserts SHALL operate normally.

Verification
REQ-034 Write x5=0xDEADBEEF, then read port 1 at x5 and port 2 at x0 -> port 1 returns 0xDEADBEEF, port 2 returns 0, wr_cnt_o=1.
REQ-035 Same cycle: we_i=1, waddr_i=7, wdata_i=0x1234, reg2 reading x7 -> reg2_rdata_o=0x1234 before the edge; write x0=0xFFFF -> x0 still reads 0 and wr_cnt_o is unchanged.
REQ-036 Reserve x3; next cycle read x3 -> reg1_busy_o=1; during the write-back cycle of x3 -> busy=0 combinationally; after the edge busy stays 0.
REQ-037 Same edge: rsv_i=1 on x4 and we_i=1 on x4 -> busy[4]=1 afterwards and data updated; reserve x0 -> busy is never 1.
REQ-038 Fill x1..x31 with nonzero values, reserve x9, assert rst asynchronously mid-cycle -> all reads 0, busy 0 and wr_cnt_o 0 immediately, without waiting for a clk edge.
REQ-039 Preload wr_cnt_o to 0xFFFFFFFF via writes (or force), then one more write -> wr_cnt_o=0.
